bin_to_onehot: RTL and testbench

- Registered binary-to-one-hot decoder.
- Takes a BIN_W-bit index and drives a ONE_HOT_W-bit vector with exactly one bit set, at the position given by the index.
- Used wherever a binary select must become per-line enables, e.g. mux selects, arbiter grants or register write strobes.
- Output is registered with 1-cycle latency and carries a valid flag and an out-of-range flag.

---
 rtl/bin_to_onehot_if.sv | 34 +++
 rtl/bin_to_onehot.sv | 81 ++++++++
 tb/tb_bin_to_onehot.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bin_to_onehot_if.sv
// Bundle for the bin_to_onehot decoder: request side (valid_i/bin_i) and registered result side.
// The self-check outputs exist only when BIN_TO_ONEHOT_CHECK_EN is defined.
interface bin_to_onehot_if #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16
);
    logic                 valid_i;
    logic [BIN_W-1:0]     bin_i;
    logic [ONE_HOT_W-1:0] one_hot_o;
    logic                 valid_o;
    logic                 oor_o;
`ifdef BIN_TO_ONEHOT_CHECK_EN
    logic [BIN_W-1:0]     chk_bin_o;
    logic                 chk_err_o;

    modport master (
        output valid_i, bin_i,
        input  one_hot_o, valid_o, oor_o, chk_bin_o, chk_err_o
    );
    modport slave (
        input  valid_i, bin_i,
        output one_hot_o, valid_o, oor_o, chk_bin_o, chk_err_o
    );
`else
    modport master (
        output valid_i, bin_i,
        input  one_hot_o, valid_o, oor_o
    );
    modport slave (
        input  valid_i, bin_i,
        output one_hot_o, valid_o, oor_o
    );
`endif
endinterface

// File: rtl/bin_to_onehot.sv
// Registered binary-to-one-hot decoder with valid and out-of-range flags, 1-cycle latency.
// Optional self-check encoder/comparator enabled by macro BIN_TO_ONEHOT_CHECK_EN.
module bin_to_onehot #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    bin_to_onehot_if.slave bus
);

    if (BIN_W < 1 || BIN_W > 16 || ONE_HOT_W < 1 || ONE_HOT_W > (1 << BIN_W)) begin : g_param_err
        $error("bin_to_onehot: illegal BIN_W=%0d / ONE_HOT_W=%0d", BIN_W, ONE_HOT_W);
    end

    logic [ONE_HOT_W-1:0] dec_p0;
    logic                 oor_p0;
    logic [ONE_HOT_W-1:0] one_hot_p1;
    logic                 vld_p1;
    logic                 oor_p1;

    // Stage p0: one comparator per output line; an index that matches no line is out of range.
    for (genvar k = 0; k < ONE_HOT_W; k++) begin : g_dec
        assign dec_p0[k] = (bus.bin_i == BIN_W'(k));
    end
    assign oor_p0 = ~|dec_p0;

    // Stage p1: output register; result and oor only update on accepted inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            one_hot_p1 <= '0;
            vld_p1     <= 1'b0;
            oor_p1     <= 1'b0;
        end else begin
            vld_p1 <= bus.valid_i;
            if (bus.valid_i) begin
                one_hot_p1 <= dec_p0;
                oor_p1     <= oor_p0;
            end
        end
    end

    assign bus.one_hot_o = one_hot_p1;
    assign bus.valid_o   = vld_p1;
    assign bus.oor_o     = oor_p1;

`ifdef BIN_TO_ONEHOT_CHECK_EN
    function automatic logic [BIN_W-1:0] encode_or(input logic [ONE_HOT_W-1:0] oh);
        logic [BIN_W-1:0] b;
        b = '0;
        for (int k = 0; k < ONE_HOT_W; k++) begin
            if (oh[k]) b = b | BIN_W'(k);
        end
        return b;
    endfunction

    function automatic logic is_onehot(input logic [ONE_HOT_W-1:0] oh);
        return (oh != '0) && ((oh & (oh - ONE_HOT_W'(1))) == '0);
    endfunction

    logic [BIN_W-1:0] bin_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_p1 <= '0;
        end else if (bus.valid_i) begin
            bin_p1 <= bus.bin_i;
        end
    end

    // Re-encode the driven output so that any upset on the output register is caught.
    assign bus.chk_bin_o = encode_or(bus.one_hot_o);
    assign bus.chk_err_o = vld_p1 && !oor_p1 &&
                           ((bus.chk_bin_o != bin_p1) || !is_onehot(bus.one_hot_o));
`endif

    a_bin_known: assert property (@(posedge clk) disable iff (!reset_n)
                                  bus.valid_i |-> !$isunknown(bus.bin_i))
        else $error("bin_to_onehot: bin_i unknown while valid_i=1");

endmodule

// File: tb/tb_bin_to_onehot.sv
// Directed bench for bin_to_onehot: one 16-line and one 10-line instance on a shared clock/reset.
module tb_bin_to_onehot;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [3:0] rb;

    always #5 clk = ~clk;

    bin_to_onehot_if #(.BIN_W(4), .ONE_HOT_W(16)) bus16 ();
    bin_to_onehot_if #(.BIN_W(4), .ONE_HOT_W(10)) bus10 ();

    bin_to_onehot #(.BIN_W(4), .ONE_HOT_W(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16)
    );
    bin_to_onehot #(.BIN_W(4), .ONE_HOT_W(10)) u_dut10 (
        .clk(clk), .reset_n(reset_n), .bus(bus10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus16.valid_i = 1'b1;
        bus16.bin_i   = 4'h5;
        bus10.valid_i = 1'b0;
        bus10.bin_i   = 4'h0;

        // Held in reset with a valid request pending.
        step();
        step();
        check("rst_one_hot", 32'(bus16.one_hot_o), 32'h0000);
        check("rst_valid",   32'(bus16.valid_o),   32'h0);
        check("rst_oor",     32'(bus16.oor_o),     32'h0);

        reset_n = 1'b1;
        step();
        check("first_after_rst", 32'(bus16.one_hot_o), 32'h0020);
        check("first_valid",     32'(bus16.valid_o),   32'h1);

        // Asynchronous assertion mid-cycle.
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_one_hot", 32'(bus16.one_hot_o), 32'h0000);
        check("async_rst_valid",   32'(bus16.valid_o),   32'h0);
        step();
        reset_n = 1'b1;

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            bus16.bin_i   = 4'(i);
            bus16.valid_i = 1'b1;
            step();
            check($sformatf("sweep_oh_%0d", i), 32'(bus16.one_hot_o), 32'h1 << i);
            check($sformatf("sweep_vld_%0d", i), 32'(bus16.valid_o), 32'h1);
            check($sformatf("sweep_oor_%0d", i), 32'(bus16.oor_o), 32'h0);
`ifdef BIN_TO_ONEHOT_CHECK_EN
            check($sformatf("chk_bin_%0d", i), 32'(bus16.chk_bin_o), 32'(i));
            check($sformatf("chk_err_%0d", i), 32'(bus16.chk_err_o), 32'h0);
`endif
        end

`ifdef BIN_TO_ONEHOT_CHECK_EN
        bus16.valid_i = 1'b0;
        force bus16.one_hot_o = 16'h0003;
        #1;
        check("chk_err_forced", 32'(bus16.chk_err_o), 32'h1);
        release bus16.one_hot_o;
        #1;
        check("chk_err_released", 32'(bus16.chk_err_o), 32'h0);
        step();
`endif

        // Random indices.
        for (int i = 0; i < 32; i++) begin
            rb = 4'($urandom_range(0, 15));
            bus16.bin_i   = rb;
            bus16.valid_i = 1'b1;
            step();
            check($sformatf("rand_oh_%0d", i), 32'(bus16.one_hot_o), 32'h1 << rb);
            check($sformatf("rand_onehot_%0d", i), 32'($onehot(bus16.one_hot_o)), 32'h1);
        end

        // Hold behaviour.
        bus16.bin_i   = 4'h3;
        bus16.valid_i = 1'b1;
        step();
        check("hold_load", 32'(bus16.one_hot_o), 32'h0008);
        bus16.bin_i   = 4'hA;
        bus16.valid_i = 1'b0;
        step();
        check("hold_oh",    32'(bus16.one_hot_o), 32'h0008);
        check("hold_valid", 32'(bus16.valid_o),   32'h0);
        check("hold_oor",   32'(bus16.oor_o),     32'h0);

        // Out-of-range on the 10-line instance.
        bus10.bin_i   = 4'd9;
        bus10.valid_i = 1'b1;
        step();
        check("oor9_oh",  32'(bus10.one_hot_o), 32'h200);
        check("oor9_oor", 32'(bus10.oor_o),     32'h0);
        bus10.bin_i = 4'd12;
        step();
        check("oor12_oh",    32'(bus10.one_hot_o), 32'h000);
        check("oor12_oor",   32'(bus10.oor_o),     32'h1);
        check("oor12_valid", 32'(bus10.valid_o),   32'h1);
        check("oor12_inv",   32'($onehot(bus10.one_hot_o) ^ bus10.oor_o), 32'h1);
        bus10.bin_i = 4'd10;
        step();
        check("oor10_oh",  32'(bus10.one_hot_o), 32'h000);
        check("oor10_oor", 32'(bus10.oor_o),     32'h1);
        bus10.bin_i = 4'd0;
        step();
        check("in0_oh",  32'(bus10.one_hot_o), 32'h001);
        check("in0_oor", 32'(bus10.oor_o),     32'h0);
        bus10.bin_i = 4'd15;
        step();
        bus10.valid_i = 1'b0;
        bus10.bin_i   = 4'd2;
        step();
        check("oor_hold_oh",    32'(bus10.one_hot_o), 32'h000);
        check("oor_hold_oor",   32'(bus10.oor_o),     32'h1);
        check("oor_hold_valid", 32'(bus10.valid_o),   32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
